imem_loader: RTL and testbench

//  Write-side counterpart of the instruction memory: receives a byte stream (e.g. from a UART RX)
//  and programs instruction words into IMEM via a synchronous write port.

---
 rtl/imem_loader.sv | 182 ++++++++++++++++++
 tb/tb_imem_loader.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader: programs IMEM from a length-prefixed byte stream and holds the CPU in reset until
// the whole image is written. Optional trailing checksum byte: define IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int          IMEM_DEPTH = 128,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        wr_en,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        cpu_rst_n
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEN0  = 3'd1,
    S_LEN1  = 3'd2,
    S_DATA  = 3'd3,
    S_CKSUM = 3'd4,
    S_DONE  = 3'd5,
    S_ERR   = 3'd6
  } state_t;

  localparam logic [16:0] DEPTH_C = 17'(IMEM_DEPTH);

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_t FINAL_C = S_CKSUM;
`else
  localparam state_t FINAL_C = S_DONE;
`endif

  state_t      state_r;
  state_t      nxt_state_s;
  logic        byte_ready_r;
  logic        wr_en_r;
  logic        busy_r;
  logic        done_r;
  logic        error_r;
  logic        cpu_rst_n_r;
  logic [31:0] wr_addr_r;
  logic [31:0] wr_data_r;
  logic [15:0] len_r;
  logic [15:0] idx_r;
  logic [1:0]  byte_cnt_r;
  logic [23:0] word_r;

  logic        accept_s;
  logic        restart_s;
  logic        last_word_s;
  logic [15:0] len_full_s;

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]  sum_r;

  function automatic logic [7:0] sum8(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction
`endif

  assign accept_s    = byte_valid & byte_ready_r;
  assign restart_s   = start & ((state_r == S_IDLE) | (state_r == S_DONE) | (state_r == S_ERR));
  assign len_full_s  = {byte_data, len_r[7:0]};
  assign last_word_s = ((idx_r + 16'd1) == len_r);

  // Next-state decode; every state transition is driven by start or an accepted byte.
  always_comb begin
    nxt_state_s = state_r;
    case (state_r)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) nxt_state_s = S_LEN0;
        else       nxt_state_s = state_r;
      end
      S_LEN0: begin
        if (accept_s) nxt_state_s = S_LEN1;
        else          nxt_state_s = state_r;
      end
      S_LEN1: begin
        if (!accept_s)                         nxt_state_s = state_r;
        else if (len_full_s == 16'd0)          nxt_state_s = FINAL_C;
        else if ({1'b0, len_full_s} > DEPTH_C) nxt_state_s = S_ERR;
        else                                   nxt_state_s = S_DATA;
      end
      S_DATA: begin
        if (accept_s && (byte_cnt_r == 2'd3) && last_word_s) nxt_state_s = FINAL_C;
        else                                                 nxt_state_s = state_r;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CKSUM: begin
        if (!accept_s)               nxt_state_s = state_r;
        else if (byte_data == sum_r) nxt_state_s = S_DONE;
        else                         nxt_state_s = S_ERR;
      end
`endif
      default: nxt_state_s = S_IDLE;
    endcase
  end

  // FSM register with outputs decoded from the next state so they line up with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= S_IDLE;
      byte_ready_r <= 1'b0;
      wr_en_r      <= 1'b0;
      wr_addr_r    <= 32'h0000_0000;
      wr_data_r    <= 32'h0000_0000;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      error_r      <= 1'b0;
      cpu_rst_n_r  <= 1'b0;
      len_r        <= 16'd0;
      idx_r        <= 16'd0;
      byte_cnt_r   <= 2'd0;
      word_r       <= 24'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_r        <= 8'd0;
`endif
    end else begin
      state_r      <= nxt_state_s;
      byte_ready_r <= (nxt_state_s == S_LEN0) | (nxt_state_s == S_LEN1) |
                      (nxt_state_s == S_DATA) | (nxt_state_s == S_CKSUM);
      busy_r       <= (nxt_state_s == S_LEN0) | (nxt_state_s == S_LEN1) |
                      (nxt_state_s == S_DATA) | (nxt_state_s == S_CKSUM);
      done_r       <= (nxt_state_s == S_DONE);
      error_r      <= (nxt_state_s == S_ERR);
      cpu_rst_n_r  <= (nxt_state_s == S_DONE);
      wr_en_r      <= 1'b0;

      if (restart_s) begin
        idx_r      <= 16'd0;
        byte_cnt_r <= 2'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        sum_r      <= 8'd0;
`endif
      end else if (accept_s) begin
        case (state_r)
          S_LEN0: len_r[7:0]  <= byte_data;
          S_LEN1: len_r[15:8] <= byte_data;
          S_DATA: begin
            byte_cnt_r <= byte_cnt_r + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_r      <= sum8(sum_r, byte_data);
`endif
            // Little-endian assembly: the fourth byte completes the word and fires the write.
            case (byte_cnt_r)
              2'd0: word_r[7:0]   <= byte_data;
              2'd1: word_r[15:8]  <= byte_data;
              2'd2: word_r[23:16] <= byte_data;
              2'd3: begin
                wr_en_r   <= 1'b1;
                wr_data_r <= {byte_data, word_r};
                wr_addr_r <= BASE_ADDR + {14'd0, idx_r, 2'b00};
                idx_r     <= idx_r + 16'd1;
              end
              default: word_r <= word_r;
            endcase
          end
          default: len_r <= len_r;
        endcase
      end else begin
        len_r <= len_r;
      end
    end
  end

  assign byte_ready = byte_ready_r;
  assign wr_en      = wr_en_r;
  assign wr_addr    = wr_addr_r;
  assign wr_data    = wr_data_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign error      = error_r;
  assign cpu_rst_n  = cpu_rst_n_r;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: a stream-level model (byte counts, arithmetic word assembly) checked
// every cycle, plus literal expectations on the directed test streams.
module tb_imem_loader;

  localparam int          DEPTH = 128;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        busy;
  logic        done;
  logic        error;
  logic        cpu_rst_n;

  always #5 clk = ~clk;

  imem_loader #(.IMEM_DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(byte_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .error(error), .cpu_rst_n(cpu_rst_n)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
    end
  endtask

  // Stream-level model: where we are in the image is just the number of accepted bytes.
  typedef enum {M_IDLE, M_LOAD, M_DONE, M_ERR} mph_t;
  mph_t        m_ph;
  int          m_nb;
  int          m_len;
  logic [7:0]  m_sum;
  logic [31:0] m_acc;
  logic [31:0] m_addr;
  logic [31:0] m_data;
  logic        m_wr;

  logic [31:0] wlog_a[$];
  logic [31:0] wlog_d[$];
  logic [7:0]  stream[$];

  task automatic m_reset();
    m_ph = M_IDLE; m_nb = 0; m_len = 0; m_sum = 8'h00;
    m_acc = 32'h0; m_addr = 32'h0; m_data = 32'h0; m_wr = 1'b0;
  endtask

  task automatic m_finish();
`ifdef IMEM_LOADER_CHECKSUM_EN
    m_ph = M_LOAD;   // one more byte, the checksum, is still expected
`else
    m_ph = M_DONE;
`endif
  endtask

  task automatic m_step();
    int p;
    int k;
    m_wr = 1'b0;
    if (m_ph == M_LOAD) begin
      if (byte_valid) begin
        if (m_nb == 0) begin
          m_len = int'(byte_data);
        end else if (m_nb == 1) begin
          m_len = m_len + 256 * int'(byte_data);
          if (m_len == 0)          m_finish();
          else if (m_len > DEPTH)  m_ph = M_ERR;
        end else if (m_nb < 2 + 4 * m_len) begin
          p = (m_nb - 2) % 4;
          k = (m_nb - 2) / 4;
          m_acc[8*p +: 8] = byte_data;
          m_sum = m_sum + byte_data;
          if (p == 3) begin
            m_wr   = 1'b1;
            m_addr = BASE + 32'(4 * k);
            m_data = m_acc;
            if (k == m_len - 1) m_finish();
          end
        end else begin
          m_ph = (byte_data == m_sum) ? M_DONE : M_ERR;
        end
        m_nb++;
      end
    end else if (start) begin
      m_ph = M_LOAD; m_nb = 0; m_sum = 8'h00;
    end
  endtask

  // Compare process: checks on the falling edge, then advances the model across the next rising edge.
  initial begin
    m_reset();
    forever begin
      @(negedge clk);
      if (!rst_n) m_reset();
      chk("byte_ready", {31'd0, byte_ready}, {31'd0, m_ph == M_LOAD});
      chk("busy",       {31'd0, busy},       {31'd0, m_ph == M_LOAD});
      chk("done",       {31'd0, done},       {31'd0, m_ph == M_DONE});
      chk("error",      {31'd0, error},      {31'd0, m_ph == M_ERR});
      chk("cpu_rst_n",  {31'd0, cpu_rst_n},  {31'd0, m_ph == M_DONE});
      chk("wr_en",      {31'd0, wr_en},      {31'd0, m_wr});
      chk("wr_addr",    wr_addr, m_addr);
      chk("wr_data",    wr_data, m_data);
      if (wr_en === 1'b1) begin
        chk("wr_align", {30'd0, wr_addr[1:0]}, 32'd0);
        wlog_a.push_back(wr_addr);
        wlog_d.push_back(wr_data);
      end
      if (rst_n) m_step();
    end
  end

  task automatic cyc(input logic s, input logic v, input logic [7:0] d);
    start = s; byte_valid = v; byte_data = d;
    @(posedge clk);
    #1;
    start = 1'b0; byte_valid = 1'b0; byte_data = 8'hEE;
  endtask

  task automatic build_prog(input logic [7:0] trailer);
    stream.delete();
    stream.push_back(8'h02); stream.push_back(8'h00);
    stream.push_back(8'h13); stream.push_back(8'h00); stream.push_back(8'h00); stream.push_back(8'h00);
    stream.push_back(8'h93); stream.push_back(8'h00); stream.push_back(8'h10); stream.push_back(8'h00);
`ifdef IMEM_LOADER_CHECKSUM_EN
    stream.push_back(trailer);
`else
    if (trailer == 8'h00) stream.push_back(8'h00);   // never taken for the real trailers
    else                  stream = stream;
`endif
  endtask

  task automatic send_stream(input bit gaps, input int start_at);
    for (int i = 0; i < stream.size(); i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) cyc(1'b0, 1'b0, 8'hEE);
      cyc(i == start_at, 1'b1, stream[i]);
    end
  endtask

  task automatic check_prog(input string tag, input int wb);
    chk({tag, "_nwr"}, 32'(wlog_a.size() - wb), 32'd2);
    if (wlog_a.size() - wb == 2) begin
      chk({tag, "_a0"}, wlog_a[wb],     32'h0000_0000);
      chk({tag, "_d0"}, wlog_d[wb],     32'h0000_0013);
      chk({tag, "_a1"}, wlog_a[wb + 1], 32'h0000_0004);
      chk({tag, "_d1"}, wlog_d[wb + 1], 32'h0010_0093);
    end
    chk({tag, "_done"}, {31'd0, done},      32'd1);
    chk({tag, "_cpu"},  {31'd0, cpu_rst_n}, 32'd1);
  endtask

  initial begin
    int wb;
    rst_n = 1'b0; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cpu",  {31'd0, cpu_rst_n},  32'd0);
    chk("rst_rdy",  {31'd0, byte_ready}, 32'd0);
    chk("rst_addr", wr_addr,             32'd0);
    rst_n = 1'b1;
    cyc(1'b0, 1'b0, 8'h00);

    // Basic two-word image; start arrives together with a byte that must be dropped.
    wb = wlog_a.size();
    build_prog(8'hB6);
    cyc(1'b1, 1'b1, 8'h55);
    send_stream(1'b0, -1);
    repeat (3) cyc(1'b0, 1'b0, 8'h00);
    check_prog("t1", wb);

    // Same image from DONE with random valid gaps.
    wb = wlog_a.size();
    cyc(1'b1, 1'b0, 8'h00);
    chk("t2_done_clr", {31'd0, done}, 32'd0);
    send_stream(1'b1, -1);
    repeat (3) cyc(1'b0, 1'b0, 8'h00);
    check_prog("t2", wb);

    // Oversized length: error right after LEN1, no writes.
    wb = wlog_a.size();
    cyc(1'b1, 1'b0, 8'h00);
    cyc(1'b0, 1'b1, 8'h81);
    cyc(1'b0, 1'b1, 8'h00);
    chk("t3_err",  {31'd0, error},      32'd1);
    chk("t3_cpu",  {31'd0, cpu_rst_n},  32'd0);
    chk("t3_rdy",  {31'd0, byte_ready}, 32'd0);
    repeat (3) cyc(1'b0, 1'b1, 8'h13);
    chk("t3_nwr",  32'(wlog_a.size() - wb), 32'd0);

    // Zero length: done with no writes.
    wb = wlog_a.size();
    cyc(1'b1, 1'b0, 8'h00);
    cyc(1'b0, 1'b1, 8'h00);
    cyc(1'b0, 1'b1, 8'h00);
`ifdef IMEM_LOADER_CHECKSUM_EN
    cyc(1'b0, 1'b1, 8'h00);
`endif
    repeat (2) cyc(1'b0, 1'b0, 8'h00);
    chk("t4_done", {31'd0, done},  32'd1);
    chk("t4_err",  {31'd0, error}, 32'd0);
    chk("t4_nwr",  32'(wlog_a.size() - wb), 32'd0);

    // Reset in the middle of a load, then a clean reload.
    wb = wlog_a.size();
    build_prog(8'hB6);
    cyc(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, stream[i]);
    cyc(1'b0, 1'b1, stream[6]);
    rst_n = 1'b0;
    cyc(1'b0, 1'b0, 8'h00);
    chk("t5_busy", {31'd0, busy},      32'd0);
    chk("t5_wren", {31'd0, wr_en},     32'd0);
    chk("t5_addr", wr_addr,            32'd0);
    chk("t5_data", wr_data,            32'd0);
    chk("t5_cpu",  {31'd0, cpu_rst_n}, 32'd0);
    chk("t5_nwr",  32'(wlog_a.size() - wb), 32'd1);
    rst_n = 1'b1;
    cyc(1'b0, 1'b0, 8'h00);
    wb = wlog_a.size();
    cyc(1'b1, 1'b0, 8'h00);
    send_stream(1'b0, -1);
    repeat (3) cyc(1'b0, 1'b0, 8'h00);
    check_prog("t5", wb);

    // start pulsed mid-DATA is ignored.
    wb = wlog_a.size();
    cyc(1'b1, 1'b0, 8'h00);
    send_stream(1'b0, 5);
    repeat (3) cyc(1'b0, 1'b0, 8'h00);
    check_prog("t7", wb);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Wrong checksum trailer: words written, then error.
    wb = wlog_a.size();
    build_prog(8'hB5);
    cyc(1'b1, 1'b0, 8'h00);
    send_stream(1'b0, -1);
    repeat (2) cyc(1'b0, 1'b0, 8'h00);
    chk("t6_err", {31'd0, error},     32'd1);
    chk("t6_cpu", {31'd0, cpu_rst_n}, 32'd0);
    chk("t6_nwr", 32'(wlog_a.size() - wb), 32'd2);
`endif

    // Full-depth image: N == IMEM_DEPTH is legal, word k = {k,k,k,k}, byte sum is 0.
    wb = wlog_a.size();
    cyc(1'b1, 1'b0, 8'h00);
    cyc(1'b0, 1'b1, 8'h80);
    cyc(1'b0, 1'b1, 8'h00);
    for (int k = 0; k < DEPTH; k++) repeat (4) cyc(1'b0, 1'b1, 8'(k));
`ifdef IMEM_LOADER_CHECKSUM_EN
    cyc(1'b0, 1'b1, 8'h00);
`endif
    repeat (2) cyc(1'b0, 1'b0, 8'h00);
    chk("t8_nwr",  32'(wlog_a.size() - wb), 32'd128);
    chk("t8_last_a", wlog_a[wlog_a.size() - 1], 32'h0000_01FC);
    chk("t8_last_d", wlog_d[wlog_d.size() - 1], 32'h7F7F_7F7F);
    chk("t8_done", {31'd0, done}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
